// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and entry type for the fetch queue stage
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Address step between consecutive sequential fetches.
  localparam int PC_INC = 4;

  // Value driven on the Decode bundle while no instruction is present.
  localparam logic [XLEN_DEFAULT-1:0] NOP_BUBBLE = '0;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with clear, occupancy count and head view
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Pointer/occupancy next state; clear overrides any push or pop in the same cycle.
  always_comb begin
    do_push  = push_i && !clear_i;
    do_pop   = pop_i && !clear_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_d = count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is not reset: the head is only consumed while count is nonzero.
  always_ff @(posedge clk) begin
    if (do_push && rst) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue_stage.sv
// rtl/fetch_queue_stage.sv - PC owner, memory request issue and instruction queue to Decode (option: FETCH_BYPASS_EN)
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            StallD,
  output logic            IMemReq,
  output logic [XLEN-1:0] IMemAddr,
  input  logic            IMemGnt,
  input  logic            IMemRValid,
  input  logic [XLEN-1:0] IMemRData,
  output logic            ValidD,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D
);

  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam int              EW      = 2 * XLEN;
  localparam logic [XLEN-1:0] STEP    = XLEN'(PC_INC);
  localparam logic [XLEN-1:0] BUBBLE  = XLEN'(NOP_BUBBLE);
  localparam logic [CW:0]     CREDITS = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rpc_q, rpc_d;     // PC of the next response that will be kept
  logic [CW-1:0]   out_q, out_d;     // granted requests whose response has not returned
  logic [CW-1:0]   drop_q, drop_d;   // wrong-path responses still to be discarded

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic [EW-1:0]   fifo_head;
  logic [CW:0]     in_use;
  logic            grant, accept, bypass, push, pop;

  // Request issue: a slot is reserved for every in-flight request so the queue can never overflow.
  always_comb begin
    in_use   = {1'b0, fifo_count} + {1'b0, out_q};
    IMemReq  = rst && !PCSrcE && (in_use < CREDITS) && (drop_q == '0);
    IMemAddr = pc_q;
    grant    = IMemReq && IMemGnt;
  end

  // Response routing: keep, bypass or discard; a redirect discards the response arriving with it.
  always_comb begin
    accept = rst && IMemRValid && (drop_q == '0) && !PCSrcE;
`ifdef FETCH_BYPASS_EN
    bypass = accept && fifo_empty;
`else
    bypass = 1'b0;
`endif
    push   = accept && !(bypass && !StallD);
    pop    = !fifo_empty && !StallD && !PCSrcE;
  end

  // Decode bundle: queue head first, else a same-cycle bypassed response, else an all-zero bubble.
  always_comb begin
    ValidD   = 1'b0;
    InstrD   = BUBBLE;
    PCD      = BUBBLE;
    PCPlus4D = BUBBLE;
    if (!fifo_empty) begin
      ValidD        = 1'b1;
      {PCD, InstrD} = fifo_head;
      PCPlus4D      = fifo_head[EW-1:XLEN] + STEP;
    end else if (bypass) begin
      ValidD   = 1'b1;
      PCD      = rpc_q;
      InstrD   = IMemRData;
      PCPlus4D = rpc_q + STEP;
    end
  end

  // Next PC, expected response PC, outstanding and drop counters.
  always_comb begin
    pc_d   = pc_q;
    rpc_d  = rpc_q;
    out_d  = out_q;
    drop_d = drop_q;
    if (grant && !IMemRValid) begin
      out_d = out_q + CW'(1);
    end else if (!grant && IMemRValid) begin
      out_d = out_q - CW'(1);
    end
    if (PCSrcE) begin
      pc_d   = PCTargetE;
      rpc_d  = PCTargetE;
      drop_d = IMemRValid ? out_q - CW'(1) : out_q;
    end else begin
      if (grant)  pc_d  = pc_q + STEP;
      if (accept) rpc_d = rpc_q + STEP;
      if (IMemRValid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  // Stage state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      rpc_q  <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      rpc_q  <= rpc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (PCSrcE),
    .push_i      (push),
    .push_data_i ({rpc_q, IMemRData}),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb/tb_fetch_queue_stage.sv - directed and randomized checks of fetch_queue_stage against a fetch-stream model
module tb_fetch_queue_stage;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_BYPASS_EN
  localparam int          FIRST_LAT = 1;
  localparam logic        T4_VD     = 1'b0;
`else
  localparam int          FIRST_LAT = 2;
  localparam logic        T4_VD     = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst, PCSrcE, StallD, IMemReq, IMemGnt, IMemRValid, ValidD;
  logic [31:0] PCTargetE, IMemAddr, IMemRData, InstrD, PCD, PCPlus4D;

  always #5 clk = ~clk;

  fetch_queue_stage #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .StallD     (StallD),
    .IMemReq    (IMemReq),
    .IMemAddr   (IMemAddr),
    .IMemGnt    (IMemGnt),
    .IMemRValid (IMemRValid),
    .IMemRData  (IMemRData),
    .ValidD     (ValidD),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // stimulus knobs
  logic        k_rst = 1'b0;
  logic        k_redir = 1'b0;
  logic [31:0] k_target = 32'h0;
  int          k_stall_pct = 0, k_gnt_pct = 100, k_lat_min = 1, k_lat_max = 1;

  // memory model: in-order pending responses with the cycle they become visible
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          last_due = 0;

  // architectural stream model
  logic [31:0] fetch_pc = RESET_PC;
  logic [31:0] exp_pc   = RESET_PC;
  logic [31:0] gnt_log[$], del_pc[$], del_pc4[$];

  // samples of the current cycle (s_) and the previous one (p_)
  logic        s_rst = 1'b0, s_pcsrc = 1'b0, s_stall = 1'b0, s_req = 1'b0, s_gnt = 1'b0, s_rvalid = 1'b0, s_vd = 1'b0;
  logic [31:0] s_target = '0, s_addr = '0, s_pcd = '0, s_instr = '0, s_pc4 = '0;
  logic        p_rst = 1'b0, p_req = 1'b0, p_gnt = 1'b0, p_pcsrc = 1'b0;
  logic [31:0] p_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    int lat, due;
    @(posedge clk);
    cyc++;
    if (!s_rst) begin
      mq_addr.delete();
      mq_due.delete();
      last_due = 0;
      fetch_pc = RESET_PC;
      exp_pc   = RESET_PC;
    end else begin
      if (s_rvalid) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (s_pcsrc) begin
        fetch_pc = s_target;
        exp_pc   = s_target;
      end else begin
        if (s_req && s_gnt) begin
          lat = int'($urandom_range(k_lat_max, k_lat_min));
          due = cyc + lat - 1;
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          mq_addr.push_back(fetch_pc);
          mq_due.push_back(due);
          gnt_log.push_back(fetch_pc);
          fetch_pc = fetch_pc + 32'd4;
        end
        if (s_vd && !s_stall) begin
          del_pc.push_back(s_pcd);
          del_pc4.push_back(s_pc4);
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
    #1;
    rst       = k_rst;
    PCSrcE    = k_redir;
    PCTargetE = k_redir ? k_target : $urandom;
    k_redir   = 1'b0;
    StallD    = ($urandom_range(99) < k_stall_pct);
    IMemGnt   = ($urandom_range(99) < k_gnt_pct);
    if (k_rst && mq_due.size() > 0 && mq_due[0] <= cyc) begin
      IMemRValid = 1'b1;
      IMemRData  = mem_word(mq_addr[0]);
    end else begin
      IMemRValid = 1'b0;
      IMemRData  = $urandom;
    end
    @(negedge clk);
    p_rst = s_rst; p_req = s_req; p_gnt = s_gnt; p_pcsrc = s_pcsrc; p_addr = s_addr;
    s_rst = rst; s_pcsrc = PCSrcE; s_target = PCTargetE; s_stall = StallD;
    s_req = IMemReq; s_addr = IMemAddr; s_gnt = IMemGnt; s_rvalid = IMemRValid;
    s_vd = ValidD; s_pcd = PCD; s_instr = InstrD; s_pc4 = PCPlus4D;
    if (!s_vd) check("bubble_zero", s_instr | s_pcd | s_pc4, 32'h0);
    if (s_rst && s_vd && !s_pcsrc) begin
      check("stream_pcd", s_pcd, exp_pc);
      check("stream_instr", s_instr, mem_word(exp_pc));
      check("stream_pc4", s_pc4, exp_pc + 32'd4);
    end
    if (s_req) check("req_addr", s_addr, fetch_pc);
    if (!s_rst) check1("req_in_reset", s_req, 1'b0);
    if (!s_rst && !p_rst) check1("valid_in_reset", s_vd, 1'b0);
    if (p_rst && s_rst && p_req && !p_gnt && !p_pcsrc && !s_pcsrc) begin
      check1("req_hold", s_req, 1'b1);
      check("req_hold_addr", s_addr, p_addr);
    end
    check1("outstanding_bound", mq_addr.size() <= DEPTH, 1'b1);
  endtask

  task automatic do_reset();
    k_rst = 1'b0;
    repeat (2) step();
    k_rst = 1'b1;
  endtask

  initial begin
    int n;
    int bad;
    rst = 1'b0; PCSrcE = 1'b0; PCTargetE = '0; StallD = 1'b0;
    IMemGnt = 1'b0; IMemRValid = 1'b0; IMemRData = '0;

    // reset state
    k_rst = 1'b0;
    repeat (3) step();
    check1("rst_valid", s_vd, 1'b0);
    check1("rst_req", s_req, 1'b0);
    check("rst_pcd", s_pcd, 32'h0);
    check("rst_instr", s_instr, 32'h0);
    check("rst_pc4", s_pc4, 32'h0);

    // release, latency 1, always granted, never stalled
    k_rst = 1'b1; k_lat_min = 1; k_lat_max = 1; k_gnt_pct = 100; k_stall_pct = 0;
    gnt_log.delete(); del_pc.delete(); del_pc4.delete();
    step();
    n = 0;
    while (!s_vd && n < 10) begin
      step();
      n++;
    end
    check("first_valid_latency", 32'(n), 32'(FIRST_LAT));
    check("first_pcd", s_pcd, 32'h0);
    check("first_pc4", s_pc4, 32'h4);
    repeat (4) step();
    check("seq_addr0", gnt_log[0], 32'h0);
    check("seq_addr1", gnt_log[1], 32'h4);
    check("seq_addr2", gnt_log[2], 32'h8);

    // Decode stalled: grants stop at DEPTH and the PC holds
    do_reset();
    k_stall_pct = 100; k_lat_min = 1; k_lat_max = 3;
    gnt_log.delete(); del_pc.delete();
    repeat (14) step();
    check("stall_grants", 32'(gnt_log.size()), 32'(DEPTH));
    check1("stall_req_low", s_req, 1'b0);
    check1("stall_valid", s_vd, 1'b1);
    check("stall_pcd", s_pcd, 32'h0);
    check("stall_pc_hold", s_addr, 32'h10);
    k_stall_pct = 0; k_gnt_pct = 0;
    repeat (6) step();
    check("drain0", del_pc[0], 32'h0);
    check("drain1", del_pc[1], 32'h4);
    check("drain2", del_pc[2], 32'h8);
    check("drain3", del_pc[3], 32'hC);
    check("drain_count", 32'(del_pc.size()), 32'd4);

    // redirect with two requests in flight at latency 3
    do_reset();
    k_gnt_pct = 100; k_stall_pct = 0; k_lat_min = 3; k_lat_max = 3;
    gnt_log.delete(); del_pc.delete();
    step();
    step();
    k_redir = 1'b1; k_target = 32'h100;
    step();
    check("redir_inflight", 32'(mq_addr.size()), 32'd2);
    check1("redir_req_low", s_req, 1'b0);
    repeat (12) step();
    check("redir_first", del_pc[0], 32'h100);
    bad = 0;
    foreach (del_pc[i]) if (del_pc[i] < 32'h100) bad++;
    check("redir_no_wrong_path", 32'(bad), 32'd0);

    // redirect coinciding with a pop and a response
    do_reset();
    k_lat_min = 2; k_lat_max = 2;
    repeat (3) step();
    k_redir = 1'b1; k_target = 32'h200;
    step();
    del_pc.delete();
    check1("coinc_valid", s_vd, T4_VD);
    check1("coinc_resp", s_rvalid, 1'b1);
    check("coinc_inflight", 32'(mq_addr.size()), 32'd2);
    step();
    check1("coinc_empty_after", s_vd, 1'b0);
    repeat (10) step();
    check("coinc_first", del_pc[0], 32'h200);
    check("coinc_second", del_pc[1], 32'h204);

    // PC wrap at the top of the address space
    do_reset();
    k_lat_min = 1; k_lat_max = 1;
    step();
    k_redir = 1'b1; k_target = 32'hFFFF_FFFC;
    step();
    gnt_log.delete(); del_pc.delete(); del_pc4.delete();
    repeat (8) step();
    check("wrap_addr0", gnt_log[0], 32'hFFFF_FFFC);
    check("wrap_addr1", gnt_log[1], 32'h0);
    check("wrap_pcd", del_pc[0], 32'hFFFF_FFFC);
    check("wrap_pc4", del_pc4[0], 32'h0);

    // reset with three requests outstanding
    do_reset();
    k_lat_min = 4; k_lat_max = 4;
    step();
    repeat (3) step();
    check("mid_inflight", 32'(mq_addr.size()), 32'd3);
    k_rst = 1'b0;
    step();
    check1("mid_req_low", s_req, 1'b0);
    step();
    check1("mid_valid", s_vd, 1'b0);
    check1("mid_req", s_req, 1'b0);
    check("mid_outputs", s_pcd | s_instr | s_pc4, 32'h0);
    k_rst = 1'b1;
    del_pc.delete();
    step();
    repeat (10) step();
    check("mid_first", del_pc[0], RESET_PC);

    // randomized traffic with random redirects
    do_reset();
    k_lat_min = 1; k_lat_max = 5; k_gnt_pct = 70; k_stall_pct = 30;
    del_pc.delete();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 3) begin
        k_redir  = 1'b1;
        k_target = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(3) == 0) k_target = 32'hFFFF_FFF0 | (k_target & 32'hC);
      end
      step();
    end
    check1("random_progress", del_pc.size() > 200, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
